// File: rtl/pipe_ctrl.sv
// Handshake and hazard controller for a 4-stage D/E/M/W pipeline.
// Tracks which stages are occupied, stalls on RAW hazards and memory waits, squashes on redirects, and counts stall and flush events.
//
// state  | meaning
// M_IDLE | no memory access outstanding for the M-stage instruction
// M_WAIT | request issued, holding M until dmem_ack
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic        stall_D,
  input  logic        redirect_E,
  input  logic        mem_op_M,
  input  logic        dmem_ack,
  output logic        fetch_ready,
  output logic        pc_en,
  output logic        valid_D,
  output logic        valid_E,
  output logic        valid_M,
  output logic        valid_W,
  output logic        ready_E,
  output logic        ready_M,
  output logic        ready_W,
  output logic        en_D,
  output logic        en_E,
  output logic        en_M,
  output logic        en_W,
  output logic        dmem_req,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } m_state_t;

  m_state_t m_state;

  logic mem_done;
  logic go_M;
  logic go_E;
  logic go_D;
  logic ready_D;
  logic take;
  logic stall_hit;

  always_comb begin
    mem_done    = ~mem_op_M | ((m_state == M_WAIT) & dmem_ack);
    go_M        = valid_M & mem_done;
    ready_M     = ~valid_M | go_M;
    ready_W     = 1'b1;
    go_E        = valid_E & ready_M;
    ready_E     = ~valid_E | ready_M;
    go_D        = valid_D & ~stall_D & ready_E;
    ready_D     = ~valid_D | go_D;
    take        = valid_E & redirect_E & go_E;
    fetch_ready = ready_D & ~take;
    en_D        = fetch_valid & fetch_ready;
    en_E        = go_D & ~take;
    en_M        = go_E;
    en_W        = go_M;
    pc_en       = en_D | take;
    // Request only on the first M cycle of a memory op; the wait state suppresses repeats.
    dmem_req    = (m_state == M_IDLE) & valid_M & mem_op_M;
    stall_hit   = valid_D & stall_D & ready_E & ~take;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: if (valid_M && mem_op_M) m_state <= M_WAIT;
        M_WAIT: if (dmem_ack) m_state <= M_IDLE;
        default: m_state <= M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_D <= 1'b0;
      valid_E <= 1'b0;
      valid_M <= 1'b0;
      valid_W <= 1'b0;
    end else begin
      valid_W <= go_M;
      valid_M <= go_E | (valid_M & ~go_M);
      valid_E <= ~take & (go_D | (valid_E & ~go_E));
      valid_D <= ~take & (en_D | (valid_D & ~go_D));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (take) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 The block SHALL provide these inputs:
- fetch_valid  input  1  IF holds an instruction for D.
- stall_D  input  1  RAW stall request from the hazard/forward unit.
- redirect_E  input  1  E-stage instruction is a taken branch or jump.
- mem_op_M  input  1  M-stage instruction is a load or store.
- dmem_ack  input  1  data memory completion.
REQ-003 The block SHALL provide these outputs:
- fetch_ready  output  1  D accepts fetch this cycle.
- pc_en  output  1  PC register load enable.
- valid_D, valid_E, valid_M, valid_W  output  1 each  stage-occupied flags.
- ready_E, ready_M, ready_W  output  1 each  stage can accept this cycle.
- en_D, en_E, en_M, en_W  output  1 each  payload-register load enables.
- dmem_req  output  1  memory request pulse.
- stall_cnt  output  32  RAW stall cycle counter.
- flush_cnt  output  16  redirect counter.

Function
REQ-004 Each stage valid flag SHALL be a flip-flop; all ready/enable outputs SHALL be combinational from the current state and inputs.
REQ-005 The M-stage FSM SHALL have two states, M_IDLE and M_WAIT:
- M_IDLE with valid_M=1 and mem_op_M=1: dmem_req=1 for exactly that cycle; next state M_WAIT.
- M_WAIT: on dmem_ack=1, next state M_IDLE.
- dmem_ack in M_IDLE SHALL be ignored.
REQ-006 mem_done SHALL be 1 when mem_op_M=0, or when the FSM is in M_WAIT and dmem_ack=1; a memory operation therefore occupies M for at least 2 cycles.
REQ-007 Stage advance and ready terms SHALL be:
- ready_W = 1 (W completes in one cycle).
- go_M = valid_M & mem_done; ready_M = ~valid_M | go_M.
- go_E = valid_E & ready_M; ready_E = ~valid_E | ready_M.
- go_D = valid_D & ~stall_D & ready_E; ready_D = ~valid_D | go_D.
REQ-008 take = valid_E & redirect_E & go_E. A redirect SHALL act only when its E-stage instruction advances; while E is held, the datapath keeps redirect_E asserted.
REQ-009 Next-state rules:
- valid_W' = go_M.
- valid_M' = go_E | (valid_M & ~go_M).
- valid_E' = ~take & (go_D | (valid_E & ~go_E)).
- valid_D' = ~take & ((fetch_valid & fetch_ready) | (valid_D & ~go_D)).
REQ-010 fetch_ready SHALL equal ready_D & ~take.
REQ-011 Payload-register load enables SHALL be:
- en_D = fetch_valid & fetch_ready.
- en_E = go_D & ~take.
- en_M = go_E.
- en_W = go_M.
REQ-012 pc_en SHALL equal en_D | take; on take the PC loads the redirect target and the fetched word is dropped.
REQ-013 On take, the instructions in D and E SHALL be squashed (valid 0 next cycle), and the branch itself SHALL advance to M.
REQ-014 stall_cnt SHALL increment by 1 each cycle with valid_D=1, stall_D=1, ready_E=1 and take=0, saturating at 0xFFFFFFFF.
REQ-015 flush_cnt SHALL increment by 1 per take cycle, wrapping modulo 2^16.
REQ-016 Simultaneous take and stall_D=1 SHALL count as a flush only; stall_cnt SHALL hold.
REQ-017 stall_D and fetch_valid SHALL be ignored whenever they have no effect under REQ-007 to REQ-011.

Reset
REQ-018 While rst=1, regardless of clk, the block SHALL hold:
- all valid flags 0;
- FSM in M_IDLE;
- dmem_req 0;
- stall_cnt 0 and flush_cnt 0.
REQ-019 Reset asserted mid-operation SHALL abandon any outstanding memory wait. A dmem_ack arriving after reset release SHALL be ignored.
REQ-020 In the first cycle after reset, with fetch_valid=1: fetch_ready=1, pc_en=1, ready_E=ready_M=ready_W=1.

Verification
REQ-021 Streaming: fetch_valid=1 for 6 cycles with no stall, no mem_op, no redirect -> valid_W=1 from cycle 4 onward; pc_en=1 every cycle; stall_cnt=0.
REQ-022 RAW stall: stall_D=1 for 2 cycles while valid_D=1 -> en_E=0, fetch_ready=0 and pc_en=0 during those cycles; valid_E=0 bubble afterwards; stall_cnt=2.
REQ-023 Load wait: mem_op_M=1 with dmem_ack arriving 3 cycles after dmem_req -> dmem_req is a single 1-cycle pulse; M is held 4 cycles; ready_E=0 and E/D frozen throughout; valid_W=1 the cycle after the ack.
REQ-024 Redirect: redirect_E=1 with valid_D=valid_E=1 and M free -> pc_en=1, fetch_ready=0; next cycle valid_D=valid_E=0 and valid_M=1; flush_cnt=1.
REQ-025 Redirect during memory wait: redirect_E=1 while M is in M_WAIT -> no squash until the ack cycle; take occurs in that cycle; flush_cnt increments exactly once.
REQ-026 Reset mid-wait: rst pulsed in M_WAIT, then dmem_ack=1 -> all valid flags 0, dmem_req=0, both counters 0, and the ack is ignored.
